// File: rtl/vector_sweep_checker_if.sv
// Stimulus/result bundle between the sweep checker and the decoder under test.
// The master side drives the sweep vector and reports results.
interface vector_sweep_checker_if;
   logic       START;
   logic       F;
   logic [3:0] ABCD;
   logic       EXP;
   logic       BUSY;
   logic       DONE;
   logic [4:0] PASS_CNT;
   logic [4:0] FAIL_CNT;
   logic       MISMATCH;
   logic [3:0] FIRST_FAIL_VEC;
   logic       FIRST_FAIL_VALID;

   modport master (
      input  START, F,
      output ABCD, EXP, BUSY, DONE, PASS_CNT, FAIL_CNT,
      output MISMATCH, FIRST_FAIL_VEC, FIRST_FAIL_VALID
   );

   modport slave (
      output START, F,
      input  ABCD, EXP, BUSY, DONE, PASS_CNT, FAIL_CNT,
      input  MISMATCH, FIRST_FAIL_VEC, FIRST_FAIL_VALID
   );
endinterface

// File: rtl/vector_sweep_checker.sv
// Clocked sweep of all 16 ABCD vectors into the 4-input decoder,
// comparing F against a built-in golden model and tallying results.
module vector_sweep_checker #(
   parameter int SETTLE_CYCLES = 2
) (
   input logic                   CLK,
   input logic                   RST,
   vector_sweep_checker_if.master bus
);
   localparam logic [3:0] SETTLE = 4'(SETTLE_CYCLES);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETTLE,
      S_SAMPLE,
      S_DONE
   } state_t;

   state_t     state_q, state_d;
   logic [3:0] abcd_q, abcd_d;
   logic [3:0] cnt_q, cnt_d;
   logic [4:0] pass_q, pass_d;
   logic [4:0] fail_q, fail_d;
   logic       mism_q, mism_d;
   logic [3:0] ffv_q, ffv_d;
   logic       ffok_q, ffok_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic       exp;

   assign exp = ~abcd_q[2] & abcd_q[0];

   always_comb begin
      state_d = state_q;
      abcd_d  = abcd_q;
      cnt_d   = cnt_q;
      pass_d  = pass_q;
      fail_d  = fail_q;
      mism_d  = 1'b0;
      ffv_d   = ffv_q;
      ffok_d  = ffok_q;
      unique case (state_q)
         S_IDLE, S_DONE: begin
            if (bus.START) begin
               abcd_d  = 4'd0;
               pass_d  = 5'd0;
               fail_d  = 5'd0;
               ffv_d   = 4'd0;
               ffok_d  = 1'b0;
               cnt_d   = SETTLE;
               state_d = S_SETTLE;
            end
         end
         S_SETTLE: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) state_d = S_SAMPLE;
         end
         S_SAMPLE: begin
            if (bus.F == exp) begin
               pass_d = pass_q + 5'd1;
            end else begin
               fail_d = fail_q + 5'd1;
               mism_d = 1'b1;
               if (!ffok_q) begin
                  ffv_d  = abcd_q;
                  ffok_d = 1'b1;
               end
            end
            // Terminal vector holds; the sweep never wraps.
            if (abcd_q == 4'd15) begin
               state_d = S_DONE;
            end else begin
               abcd_d  = abcd_q + 4'd1;
               cnt_d   = SETTLE;
               state_d = S_SETTLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d == S_SETTLE) || (state_d == S_SAMPLE);
      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= S_IDLE;
         abcd_q  <= 4'd0;
         cnt_q   <= 4'd0;
         pass_q  <= 5'd0;
         fail_q  <= 5'd0;
         mism_q  <= 1'b0;
         ffv_q   <= 4'd0;
         ffok_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         abcd_q  <= abcd_d;
         cnt_q   <= cnt_d;
         pass_q  <= pass_d;
         fail_q  <= fail_d;
         mism_q  <= mism_d;
         ffv_q   <= ffv_d;
         ffok_q  <= ffok_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign bus.ABCD             = abcd_q;
   assign bus.EXP              = exp;
   assign bus.BUSY             = busy_q;
   assign bus.DONE             = done_q;
   assign bus.PASS_CNT         = pass_q;
   assign bus.FAIL_CNT         = fail_q;
   assign bus.MISMATCH         = mism_q;
   assign bus.FIRST_FAIL_VEC   = ffv_q;
   assign bus.FIRST_FAIL_VALID = ffok_q;
endmodule
